// File: rtl/cp0_exc_seq.sv
// rtl/cp0_exc_seq.sv - CP0 exception entry / eret sequencer
// Walks Status/Cause/EPC through CP0 one access per cycle, then redirects the PC.
module cp0_exc_seq #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
  parameter logic [4:0]  ADDR_STATUS  = 5'd12,
  parameter logic [4:0]  ADDR_CAUSE   = 5'd13,
  parameter logic [4:0]  ADDR_EPC     = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        eret_req,
  input  logic [31:0] cp0_rdata,
  output logic        cp0_r,
  output logic [4:0]  cp0_raddr,
  output logic        cp0_w,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        busy,
  output logic        exc_ack,
  output logic        eret_ack,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);

  typedef enum logic [3:0] {
    IDLE, E_RDST, E_WRST, E_WRCA, E_WREPC, E_JMP,
    R_RDST, R_WRST, R_RDEPC, R_JMP
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] status_q, epc_q, exc_pc_q;
  logic [4:0]  exc_code_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (exc_req)       state_nxt = E_RDST;
        else if (eret_req) state_nxt = R_RDST;
      end
      E_RDST:  state_nxt = E_WRST;
      E_WRST:  state_nxt = E_WRCA;
      E_WRCA:  state_nxt = E_WREPC;
      E_WREPC: state_nxt = E_JMP;
      E_JMP:   state_nxt = IDLE;
      R_RDST:  state_nxt = R_WRST;
      R_WRST:  state_nxt = R_RDEPC;
      R_RDEPC: state_nxt = R_JMP;
      R_JMP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured only on acceptance, so later wiggles are harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q   <= '0;
      epc_q      <= '0;
      exc_code_q <= '0;
      exc_pc_q   <= '0;
    end else begin
      if (state == IDLE && exc_req) begin
        exc_code_q <= exc_code;
        exc_pc_q   <= exc_pc;
      end
      if (state == E_RDST || state == R_RDST) status_q <= cp0_rdata;
      if (state == R_RDEPC) epc_q <= cp0_rdata;
    end
  end

  always_comb begin
    cp0_r       = 1'b0;
    cp0_raddr   = '0;
    cp0_w       = 1'b0;
    cp0_waddr   = '0;
    cp0_wdata   = '0;
    exc_ack     = 1'b0;
    eret_ack    = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    busy        = (state != IDLE);
    case (state)
      E_RDST, R_RDST: begin
        cp0_r     = 1'b1;
        cp0_raddr = ADDR_STATUS;
      end
      E_WRST: begin
        cp0_w     = 1'b1;
        cp0_waddr = ADDR_STATUS;
        cp0_wdata = status_q << 5;
      end
      R_WRST: begin
        cp0_w     = 1'b1;
        cp0_waddr = ADDR_STATUS;
        cp0_wdata = status_q >> 5;
      end
      E_WRCA: begin
        cp0_w     = 1'b1;
        cp0_waddr = ADDR_CAUSE;
        cp0_wdata = {25'b0, exc_code_q, 2'b00};
      end
      E_WREPC: begin
        cp0_w     = 1'b1;
        cp0_waddr = ADDR_EPC;
        cp0_wdata = exc_pc_q;
      end
      R_RDEPC: begin
        cp0_r     = 1'b1;
        cp0_raddr = ADDR_EPC;
      end
      E_JMP: begin
        pc_redirect = 1'b1;
        pc_target   = HANDLER_ADDR;
        exc_ack     = 1'b1;
      end
      R_JMP: begin
        pc_redirect = 1'b1;
        pc_target   = epc_q;
        eret_ack    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cp0_exc_seq.md
CP0_EXC_SEQ -- requirements
Module: cp0_exc_seq

Interface
REQ-001 SHALL provide parameter HANDLER_ADDR, default 32'h0040_0004, exception handler entry PC.
REQ-002 SHALL provide parameter ADDR_STATUS, default 5'd12; ADDR_CAUSE, default 5'd13; ADDR_EPC, default 5'd14.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- exc_req  in  1  exception request (level, held until exc_ack).
- exc_code  in  5  ExcCode (8 syscall, 9 break, 13 teq).
- exc_pc  in  32  PC of the excepting instruction.
- eret_req  in  1  eret request (level, held until eret_ack).
- cp0_rdata  in  32  CP0 combinational read data.
- cp0_r  out  1  CP0 read enable.
- cp0_raddr  out  5  CP0 read address.
- cp0_w  out  1  CP0 write enable (CP0 captures on falling edge of the same cycle).
- cp0_waddr  out  5  CP0 write address.
- cp0_wdata  out  32  CP0 write data.
- busy  out  1  sequencer not in IDLE.
- exc_ack  out  1  one-cycle exception-done pulse.
- eret_ack  out  1  one-cycle eret-done pulse.
- pc_redirect  out  1  one-cycle PC load strobe.
- pc_target  out  32  PC to load when pc_redirect=1.

Function
REQ-004 SHALL implement states IDLE, E_RDST, E_WRST, E_WRCA, E_WREPC, E_JMP, R_RDST, R_WRST, R_RDEPC, R_JMP; one cycle per non-IDLE state, no stalls.
REQ-005 In IDLE, exc_req=1 SHALL latch exc_code and exc_pc and go to E_RDST; else eret_req=1 SHALL go to R_RDST; exc_req has priority when both are high.
REQ-006 Exception path SHALL be E_RDST -> E_WRST -> E_WRCA -> E_WREPC -> E_JMP -> IDLE (5 cycles after acceptance edge).
REQ-007 Eret path SHALL be R_RDST -> R_WRST -> R_RDEPC -> R_JMP -> IDLE (4 cycles).
REQ-008 E_RDST/R_RDST: cp0_r=1, cp0_raddr=ADDR_STATUS; cp0_rdata SHALL be latched into status_q at the closing rising edge.
REQ-009 E_WRST: cp0_w=1, cp0_waddr=ADDR_STATUS, cp0_wdata = status_q << 5 (bits 4:0 zero, bits 31:27 discarded).
REQ-010 R_WRST: cp0_w=1, cp0_waddr=ADDR_STATUS, cp0_wdata = status_q >> 5 (logical, bits 31:27 zero).
REQ-011 E_WRCA: cp0_w=1, cp0_waddr=ADDR_CAUSE, cp0_wdata = {25'b0, exc_code_q, 2'b00}.
REQ-012 E_WREPC: cp0_w=1, cp0_waddr=ADDR_EPC, cp0_wdata = exc_pc_q.
REQ-013 R_RDEPC: cp0_r=1, cp0_raddr=ADDR_EPC; cp0_rdata SHALL be latched into epc_q at the closing rising edge.
REQ-014 E_JMP: pc_redirect=1, pc_target=HANDLER_ADDR, exc_ack=1; R_JMP: pc_redirect=1, pc_target=epc_q, eret_ack=1.
REQ-015 cp0_r and cp0_w SHALL never be 1 in the same cycle; cp0_w=1 only in write states, cp0_r=1 only in read states.
REQ-016 When cp0_r=0, cp0_raddr SHALL be 0; when cp0_w=0, cp0_waddr and cp0_wdata SHALL be 0; when pc_redirect=0, pc_target SHALL be 0.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 Requests arriving or changing while busy=1 SHALL be ignored; exc_code/exc_pc changes after acceptance SHALL not affect writes.
REQ-019 A request still high in the IDLE cycle following an ack SHALL be accepted as a new request (requester must drop on ack).

Reset
REQ-020 rst=0 SHALL immediately force IDLE and drive all outputs to 0, asynchronously, including mid-sequence; no further CP0 writes from the aborted sequence.
REQ-021 status_q, epc_q, exc_code_q, exc_pc_q SHALL reset to 0.
REQ-022 After rst returns to 1, first acceptance SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-023 Syscall: cp0_rdata(Status)=32'h0000_000F, exc_req=1, exc_code=8, exc_pc=32'h0040_0020 -> writes Status=32'h0000_01E0, Cause=32'h0000_0020, EPC=32'h0040_0020, then pc_redirect with pc_target=32'h0040_0004 and exc_ack, 5 cycles after acceptance.
REQ-024 Eret: Status=32'h0000_01E0, EPC=32'h0040_0020, eret_req=1 -> writes Status=32'h0000_000F, then pc_target=32'h0040_0020 with eret_ack, 4 cycles after acceptance.
REQ-025 Simultaneous exc_req=1 (code 13) and eret_req=1 in IDLE -> exception path taken, Cause=32'h0000_0034, no eret_ack.
REQ-026 Status=32'hFFFF_FFFF on exception -> write 32'hFFFF_FFE0; on eret -> write 32'h07FF_FFFF.
REQ-027 rst=0 asserted during E_WRCA -> outputs 0 at once, EPC never written, state IDLE; new exc_req after release runs full sequence.
REQ-028 exc_code/exc_pc toggled every cycle while busy -> Cause/EPC reflect values captured at acceptance only.
